// File: rtl/mips_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_io_pkg
//  Description : Shared definitions for the MIPS memory-mapped I/O port block.
//                Provides the word-address layout helpers (inport, outport and
//                status offsets derived from the input-port count) and the
//                press-detector state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_io_pkg;

    // Press-detector state encoding (explicit 2-bit width)
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_count = 2'd1;
    localparam logic [1:0] c_st_held  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = c_st_idle,
        COUNT = c_st_count,
        HELD  = c_st_held
    } io_state_e;

    // Word address of input port 'port'
    function automatic int inport_index(input int port);
        return port;
    endfunction

    // Word address of the CPU-writable output port
    function automatic int outport_index(input int num_in);
        return num_in;
    endfunction

    // Word address of the sticky new-data status register
    function automatic int status_index(input int num_in);
        return num_in + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_io_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : mips_io_debounce
//  Description : Two-flop synchroniser followed by a press detector. A press
//                is accepted once the synchronised button has stayed high for
//                DEBOUNCE_CYCLES consecutive cycles in the counting state, and
//                produces exactly one single-cycle capture pulse per press.
//  Ports       : clk     - system clock
//                rst     - synchronous active-high reset
//                port_en - asynchronous pushbutton input
//                capture - one-cycle pulse marking an accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_io_debounce
    import mips_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic port_en,
    output logic capture
);

    localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               w_s;
    io_state_e          r_state;
    io_state_e          w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;

    assign w_s = r_sync2;

    // Synchroniser, state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= port_en;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state and counter
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_next = COUNT;
                    w_cnt_next   = c_cnt_one;
                end
            end
            COUNT: begin
                if (!w_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_next = HELD;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            HELD: begin
                // Stay here until release so a long press captures only once
                if (!w_s) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Capture pulse: the COUNT cycle that leaves for HELD
    always_comb begin
        capture = (r_state == COUNT) && w_s && (r_cnt == c_cnt_max);
    end

endmodule
`default_nettype wire

// File: rtl/mips_io_ports.sv
`default_nettype none
// ============================================================================
//  Module      : mips_io_ports
//  Description : Memory-mapped I/O port block. Holds NUM_IN input registers
//                loaded from user_input on a debounced press of port_en
//                (steered by port_sel), one CPU-writable output register that
//                drives the LEDs, and a sticky read-to-clear new-data status.
//                Address map: 0..NUM_IN-1 inports (RO), NUM_IN outport (RW),
//                NUM_IN+1 status (RO, read-to-clear), others read 0.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                port_sel          - input-port index for the next capture
//                port_en           - asynchronous pushbutton
//                user_input        - switch bank value
//                addr, wr_en,
//                wr_data, rd_en    - CPU word interface
//                rd_data           - registered read data
//                leds              - low LED_WIDTH bits of the outport
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_io_ports
    import mips_io_pkg::*;
#(
    parameter  int WIDTH           = 32,
    parameter  int NUM_IN          = 2,
    parameter  int LED_WIDTH       = 16,
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int SEL_W           = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    localparam int ADDR_W          = $clog2(NUM_IN + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL_W-1:0]     port_sel,
    input  logic                 port_en,
    input  logic [WIDTH-1:0]     user_input,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic [LED_WIDTH-1:0] leds
);

    localparam logic [ADDR_W-1:0] c_out_addr  = ADDR_W'(outport_index(NUM_IN));
    localparam logic [ADDR_W-1:0] c_stat_addr = ADDR_W'(status_index(NUM_IN));

    logic [WIDTH-1:0]  r_inport [NUM_IN];
    logic [WIDTH-1:0]  r_outport;
    logic [NUM_IN-1:0] r_flag;
    logic [WIDTH-1:0]  r_rd_data;
    logic              w_capture;
    logic [NUM_IN-1:0] w_cap_hit;
    logic [WIDTH-1:0]  w_rd_mux;
    logic              w_stat_rd;

    mips_io_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .port_en (port_en),
        .capture (w_capture)
    );

    // One-hot capture target; an out-of-range port_sel matches nothing
    always_comb begin
        w_cap_hit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_capture && (port_sel == SEL_W'(i))) begin
                w_cap_hit[i] = 1'b1;
            end
        end
    end

    // Read decode; unmapped addresses fall through to zero
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (addr == ADDR_W'(inport_index(i))) begin
                w_rd_mux = r_inport[i];
            end
        end
        if (addr == c_out_addr) begin
            w_rd_mux = r_outport;
        end
        if (addr == c_stat_addr) begin
            w_rd_mux = WIDTH'(r_flag);
        end
    end

    assign w_stat_rd = rd_en && (addr == c_stat_addr);

    // Input port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_inport[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_cap_hit[i]) begin
                    r_inport[i] <= user_input;
                end
            end
        end
    end

    // Status flags: the clear applies to the flags seen by this read, and a
    // capture in the same cycle wins so no new data is ever lost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag <= '0;
        end else begin
            r_flag <= (w_stat_rd ? '0 : r_flag) | w_cap_hit;
        end
    end

    // Output port and registered read data (both use pre-edge values)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outport <= '0;
            r_rd_data <= '0;
        end else begin
            if (wr_en && (addr == c_out_addr)) begin
                r_outport <= wr_data;
            end
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_data = r_rd_data;
    assign leds    = r_outport[LED_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mips_io_ports.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_io_ports
//  Description : Self-checking bench for mips_io_ports. Three instances share
//                the button, selector and switch inputs: default (NUM_IN=2),
//                NUM_IN=4 with 8 LEDs, and NUM_IN=3. A behavioural model built
//                on press run-length and plain register arrays predicts every
//                read and LED value each cycle; directed scenarios add fixed
//                expected values on top.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_io_ports;

    localparam int c_deb = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        port_en = 1'b0;
    logic [3:0]  port_sel = '0;
    logic [31:0] user_input = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  addr_a = '0;
    logic [2:0]  addr_b = '0;
    logic [2:0]  addr_c = '0;
    logic [2:0]  wr_en = '0;
    logic [2:0]  rd_en = '0;
    logic [31:0] rd_a, rd_b, rd_c;
    logic [15:0] leds_a, leds_c;
    logic [7:0]  leds_b;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    mips_io_ports #(.NUM_IN(2), .LED_WIDTH(16), .DEBOUNCE_CYCLES(c_deb)) u_dut_a (
        .clk(clk), .rst(rst), .port_sel(port_sel[0:0]), .port_en(port_en),
        .user_input(user_input), .addr(addr_a), .wr_en(wr_en[0]), .wr_data(wr_data),
        .rd_en(rd_en[0]), .rd_data(rd_a), .leds(leds_a));

    mips_io_ports #(.NUM_IN(4), .LED_WIDTH(8), .DEBOUNCE_CYCLES(c_deb)) u_dut_b (
        .clk(clk), .rst(rst), .port_sel(port_sel[1:0]), .port_en(port_en),
        .user_input(user_input), .addr(addr_b), .wr_en(wr_en[1]), .wr_data(wr_data),
        .rd_en(rd_en[1]), .rd_data(rd_b), .leds(leds_b));

    mips_io_ports #(.NUM_IN(3), .LED_WIDTH(16), .DEBOUNCE_CYCLES(c_deb)) u_dut_c (
        .clk(clk), .rst(rst), .port_sel(port_sel[1:0]), .port_en(port_en),
        .user_input(user_input), .addr(addr_c), .wr_en(wr_en[2]), .wr_data(wr_data),
        .rd_en(rd_en[2]), .rd_data(rd_c), .leds(leds_c));

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int          num_in_of [3] = '{2, 4, 3};
    int          sel_mask  [3] = '{1, 3, 3};
    logic [31:0] m_in   [3][16];
    logic [31:0] m_out  [3];
    logic [15:0] m_flag [3];
    logic [31:0] m_rd   [3];
    int          run = 0;        // consecutive synchronised-high cycles
    logic        pe_d1 = 1'b0;   // port_en one edge ago
    logic        pe_d2 = 1'b0;   // port_en two edges ago (synchronised value)

    function automatic logic [31:0] mapped(input int k, input int a);
        int n = num_in_of[k];
        if (a < n)       return m_in[k][a];
        if (a == n)      return m_out[k];
        if (a == n + 1)  return {16'b0, m_flag[k]};
        return 32'h0;
    endfunction

    function automatic int addr_of(input int k);
        if (k == 0) return int'(addr_a);
        if (k == 1) return int'(addr_b);
        return int'(addr_c);
    endfunction

    always @(posedge clk) begin
        bit cap;
        int n, a, sel;
        if (rst) begin
            run = 0; pe_d1 = 1'b0; pe_d2 = 1'b0;
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 16; j++) m_in[k][j] = '0;
                m_out[k] = '0; m_flag[k] = '0; m_rd[k] = '0;
            end
        end else begin
            // A press is accepted on its (DEBOUNCE+1)-th synchronised-high cycle
            if (pe_d2) begin
                if (run < 1000) run++;
            end else begin
                run = 0;
            end
            cap = (run == c_deb + 1);
            for (int k = 0; k < 3; k++) begin
                n   = num_in_of[k];
                a   = addr_of(k);
                sel = int'(port_sel) & sel_mask[k];
                if (rd_en[k]) begin
                    m_rd[k] = mapped(k, a);
                    if (a == n + 1) m_flag[k] = '0;
                end
                if (wr_en[k] && a == n) m_out[k] = wr_data;
                if (cap && sel < n) begin
                    m_in[k][sel]   = user_input;
                    m_flag[k][sel] = 1'b1;
                end
            end
            pe_d2 = pe_d1;
            pe_d1 = port_en;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_rd_a",   rd_a, m_rd[0]);
            check("model_rd_b",   rd_b, m_rd[1]);
            check("model_rd_c",   rd_c, m_rd[2]);
            check("model_leds_a", {16'b0, leds_a}, {16'b0, m_out[0][15:0]});
            check("model_leds_b", {24'b0, leds_b}, {24'b0, m_out[1][7:0]});
            check("model_leds_c", {16'b0, leds_c}, {16'b0, m_out[2][15:0]});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int n);
        port_en = 1'b1;
        repeat (n) tick();
        port_en = 1'b0;
    endtask

    task automatic read_a(input logic [1:0] a, input logic [31:0] exp, input string tag);
        addr_a = a; rd_en[0] = 1'b1;
        tick();
        rd_en[0] = 1'b0;
        check(tag, rd_a, exp);
    endtask

    initial begin
        int hold;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        chk_on = 1'b1;
        check("rst_leds", {16'b0, leds_a}, 32'h0);
        check("rst_rd",   rd_a, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) read_a(2'(i), 32'h0, "rst_read");

        // Debounced capture into port 1, exact latency
        port_sel = 4'd1; user_input = 32'h0000CAFE;
        addr_a = 2'd1; rd_en[0] = 1'b1;
        port_en = 1'b1;
        tick();                     // edge t
        repeat (5) tick();          // edges t+1..t+5
        tick();                     // edge t+6: capture edge, read returns old
        check("cap_old", rd_a, 32'h0);
        tick();                     // edge t+7
        check("cap_new", rd_a, 32'h0000CAFE);
        repeat (2) tick();
        port_en = 1'b0; rd_en[0] = 1'b0;
        read_a(2'd0, 32'h0, "cap_port0_same");
        read_a(2'd3, 32'h2, "cap_status");
        read_a(2'd3, 32'h0, "cap_status_clr");

        // Bounce rejection, then a clean long press
        user_input = 32'h0000BEEF;
        press(3);
        repeat (2) tick();
        press(3);
        repeat (8) tick();
        read_a(2'd3, 32'h0, "bounce_status");
        read_a(2'd1, 32'h0000CAFE, "bounce_port1");
        press(8);
        repeat (6) tick();
        read_a(2'd3, 32'h2, "long_status");
        read_a(2'd1, 32'h0000BEEF, "long_port1");

        // Output port write, read-back and read/write collision
        addr_a = 2'd2; wr_data = 32'h1234ABCD; wr_en[0] = 1'b1;
        tick();
        wr_en[0] = 1'b0;
        check("out_leds", {16'b0, leds_a}, 32'h0000ABCD);
        read_a(2'd2, 32'h1234ABCD, "out_read");
        wr_data = 32'h55AA55AA; wr_en[0] = 1'b1; rd_en[0] = 1'b1;
        tick();
        wr_en[0] = 1'b0; rd_en[0] = 1'b0;
        check("rdwr_old",  rd_a, 32'h1234ABCD);
        check("rdwr_leds", {16'b0, leds_a}, 32'h000055AA);
        read_a(2'd2, 32'h55AA55AA, "rdwr_new");

        // Status read in the capture cycle of port 0
        port_sel = 4'd0; user_input = 32'h11110000;
        port_en = 1'b1;
        tick();                     // edge t
        repeat (5) tick();          // up to t+5
        read_a(2'd3, 32'h0, "collide_status");   // edge t+6
        port_en = 1'b0;
        read_a(2'd3, 32'h1, "collide_flag_kept");
        read_a(2'd0, 32'h11110000, "collide_port0");

        // Reset while counting (cnt=2)
        user_input = 32'h22220000;
        port_en = 1'b1;
        repeat (4) tick();          // edges t..t+3
        rst = 1'b1; port_en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        read_a(2'd3, 32'h0, "rstcnt_status");
        read_a(2'd0, 32'h0, "rstcnt_port0");

        // Parametrised instances: capture into port 3
        port_sel = 4'd3; user_input = 32'hDEAD0004;
        press(10);
        repeat (4) tick();
        addr_b = 3'd5; addr_c = 3'd4; rd_en = 3'b110;
        tick();
        check("b_status", rd_b, 32'h8);
        check("c_status", rd_c, 32'h0);
        addr_b = 3'd3; addr_c = 3'd0;
        tick();
        check("b_port3", rd_b, 32'hDEAD0004);
        check("c_port0", rd_c, 32'h0);
        rd_en = '0;
        addr_b = 3'd4; wr_data = 32'hFFFF12C3; wr_en[1] = 1'b1;
        tick();
        wr_en[1] = 1'b0;
        check("b_leds", {24'b0, leds_b}, 32'h000000C3);

        // Randomised traffic against the model
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                port_en = ~port_en;
                hold = $urandom_range(1, 12);
            end
            hold--;
            port_sel   = 4'($urandom_range(0, 3));
            user_input = $urandom;
            wr_data    = $urandom;
            addr_a     = 2'($urandom_range(0, 3));
            addr_b     = 3'($urandom_range(0, 7));
            addr_c     = 3'($urandom_range(0, 7));
            rd_en      = 3'($urandom);
            wr_en      = 3'($urandom) & 3'($urandom);
            rst        = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0; port_en = 1'b0; rd_en = '0; wr_en = '0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
